// File: rtl/icache_assoc_pkg.sv
// icache_assoc_pkg: shared state enum, address-field widths and field extraction for icache_assoc
package icache_assoc_pkg;
  typedef enum logic [1:0] {IDLE, FILL, INSTALL} state_t;
  function automatic int off_w(input int blkwords);
    return $clog2(blkwords);
  endfunction
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(input int sets, input int blkwords);
    return 30 - $clog2(sets) - $clog2(blkwords);
  endfunction
  function automatic logic [31:0] field(input logic [31:0] addr, input int lsb, input int width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction
endpackage

// File: rtl/icache_way.sv
// icache_way: one way of the cache -- valid/tag/data arrays, combinational lookup, registered install
// Ports: clk/rst_n clock and async active-low reset; idx/tag/off lookup key -> hit/word;
// wr_idx/wr_tag/wr_data/wr install a block, wr_valid reports the valid bit at wr_idx; inv clears all valid bits.
module icache_way #(
  parameter int SETS = 8, BLKWORDS = 2, IW = 3, OW = 1, TW = 26
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [IW-1:0]              idx,
  input  logic [TW-1:0]              tag,
  input  logic [OW-1:0]              off,
  output logic                       hit,
  output logic [31:0]                word,
  input  logic [IW-1:0]              wr_idx,
  output logic                       wr_valid,
  input  logic                       wr,
  input  logic                       inv,
  input  logic [TW-1:0]              wr_tag,
  input  logic [BLKWORDS-1:0][31:0]  wr_data
);
  logic [SETS-1:0] valid;
  logic [TW-1:0] tags [SETS];
  logic [BLKWORDS-1:0][31:0] data [SETS];
  assign hit = valid[idx] && tags[idx] == tag;
  assign word = data[idx][off];
  assign wr_valid = valid[wr_idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid <= '0;
    else if (inv) valid <= '0;
    else if (wr) valid[wr_idx] <= 1'b1;
  always_ff @(posedge clk)
    if (wr) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: 1/2-way set-associative instruction cache with LRU, block refill, flush and hit/miss counters
// Ports: CLK/nRST clock and async active-low reset; imemREN/imemaddr/flush fetch request, ihit/imemload response;
// iREN/iaddr/iwait/iload memory read channel; hit_count/miss_count saturating statistics.
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int SETS = 8, WAYS = 2, BLKWORDS = 2, CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  input  logic             flush,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int OFF = off_w(BLKWORDS);
  localparam int IDX = idx_w(SETS);
  localparam int TAG = tag_w(SETS, BLKWORDS);
  localparam int OW = OFF > 0 ? OFF : 1;
  state_t state, next;
  logic [31:0] base;
  logic [OW-1:0] cnt, off;
  logic [BLKWORDS-1:0][31:0] fbuf;
  logic [SETS-1:0] lru;
  logic [1:0] hit_w, vld_w, wr_w;
  logic [31:0] word_w [2];
  logic [IDX-1:0] idx, bidx;
  logic [TAG-1:0] tag, btag;
  logic victim, last, miss;
  assign off = OW'(field(imemaddr, 2, OFF));
  assign idx = IDX'(field(imemaddr, 2 + OFF, IDX));
  assign tag = TAG'(field(imemaddr, 2 + OFF + IDX, TAG));
  assign bidx = IDX'(field(base, 2 + OFF, IDX));
  assign btag = TAG'(field(base, 2 + OFF + IDX, TAG));
  // Absent ways read as valid and never hit, so a 1-way cache always picks way 0.
  for (genvar w = 0; w < 2; w++) begin : g_way
    if (w < WAYS) begin : g_on
      icache_way #(.SETS(SETS), .BLKWORDS(BLKWORDS), .IW(IDX), .OW(OW), .TW(TAG)) u_way (
        .clk(CLK), .rst_n(nRST), .idx(idx), .tag(tag), .off(off), .hit(hit_w[w]), .word(word_w[w]),
        .wr_idx(bidx), .wr_valid(vld_w[w]), .wr(wr_w[w]), .inv(flush), .wr_tag(btag), .wr_data(fbuf)
      );
    end else begin : g_off
      assign hit_w[w] = 1'b0;
      assign vld_w[w] = 1'b1;
      assign word_w[w] = '0;
    end
  end
  // Lowest invalid way first, otherwise the way the LRU bit points at.
  assign victim = vld_w[0] & (!vld_w[1] | lru[bidx]);
  assign last = cnt == OW'(BLKWORDS - 1);
  assign miss = state == IDLE && next == FILL;
  assign wr_w = state == INSTALL && !flush ? (victim ? 2'b10 : 2'b01) : 2'b00;
  always_comb begin
    next = state;
    ihit = 1'b0;
    iREN = 1'b0;
    iaddr = '0;
    if (state == IDLE) begin
      ihit = imemREN && !flush && |hit_w;
      next = imemREN && !flush && !(|hit_w) ? FILL : IDLE;
    end else if (state == FILL) begin
      iREN = 1'b1;
      iaddr = base + (32'(cnt) << 2);
      next = flush ? IDLE : !iwait && last ? INSTALL : FILL;
    end else next = IDLE;
    imemload = ihit ? word_w[hit_w[1]] : '0;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      base <= '0;
      cnt <= '0;
      lru <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      state <= next;
      if (miss) begin
        base <= imemaddr & ~32'(BLKWORDS * 4 - 1);
        cnt <= '0;
      end else if (iREN && !iwait) cnt <= cnt + 1'b1;
      if (flush) lru <= '0;
      else if (WAYS == 2 && ihit) lru[idx] <= !hit_w[1];
      else if (WAYS == 2 && wr_w != 2'b00) lru[bidx] <= !victim;
      hit_count <= hit_count + CNT_W'(ihit && hit_count != '1);
      miss_count <= miss_count + CNT_W'(miss && miss_count != '1);
    end
  always_ff @(posedge CLK)
    if (iREN && !iwait) fbuf[cnt] <= iload;
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: scoreboard bench for icache_assoc -- directed fetches against a memory model
module tb_icache_assoc;
  logic CLK = 0, nRST = 0, imemREN = 0, flush = 0, iwait;
  logic [31:0] imemaddr = 0, iload;
  logic ihit, iREN, s_ihit, s_iREN;
  logic [31:0] imemload, iaddr, s_imemload, s_iaddr;
  logic [31:0] hit_count, miss_count;
  logic [3:0] s_hit_count, s_miss_count;
  int tests = 0, fails = 0, wait_cfg = 0, wc = 0;
  logic [31:0] exp_q[$], fill_q[$];
  logic lw = 0;
  logic [31:0] la = 0;

  icache_assoc #(.SETS(8), .WAYS(2), .BLKWORDS(2), .CNT_W(32)) u_dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );
  icache_assoc #(.SETS(8), .WAYS(2), .BLKWORDS(2), .CNT_W(4)) u_sat (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
    .ihit(s_ihit), .imemload(s_imemload), .iREN(s_iREN), .iaddr(s_iaddr), .iwait(iwait), .iload(iload),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a & ~32'd3) ^ 32'h5A5A_0000;
  endfunction

  assign iload = mem(iaddr);
  assign iwait = iREN && wc < wait_cfg;
  always @(posedge CLK) wc <= (!iREN || !iwait) ? 0 : wc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) if (nRST) begin
    if (iREN && lw) chk("iaddr_stable", iaddr, la);
    lw = iREN && iwait;
    la = iaddr;
    if (iREN && !iwait) fill_q.push_back(iaddr);
    if (iREN) chk("no_hit_in_fill", {31'b0, ihit}, 32'd0);
    if (ihit) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_hit: got imemload %h with no fetch outstanding", imemload);
      end else chk("hit_data", imemload, exp_q.pop_front());
    end else chk("load_zero", imemload, 32'd0);
  end

  task automatic fetch(input logic [31:0] a, input int lat, input string nm);
    int n = 0;
    exp_q.push_back(mem(a));
    @(posedge CLK);
    #1 imemREN = 1;
    imemaddr = a;
    @(negedge CLK);
    while (!ihit && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk({nm, "_lat"}, n, lat);
    @(posedge CLK);
    #1 imemREN = 0;
  endtask

  initial begin
    #22;
    chk("rst_ihit", {31'b0, ihit}, 0);
    chk("rst_load", imemload, 0);
    chk("rst_iren", {31'b0, iREN}, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_miss", miss_count, 0);
    #1 nRST = 1;
    fill_q.delete();
    fetch(32'h100, 4, "cold_100");
    chk("fill_n", fill_q.size(), 2);
    chk("fill_a0", fill_q[0], 32'h100);
    chk("fill_a1", fill_q[1], 32'h104);
    fetch(32'h104, 0, "hit_104");
    chk("cold_miss", miss_count, 1);
    chk("cold_hits", hit_count, 2);
    @(posedge CLK);
    #1 imemREN = 1;
    imemaddr = 32'h104;
    flush = 1;
    @(negedge CLK);
    chk("flush_nohit", {31'b0, ihit}, 0);
    @(posedge CLK);
    #1 flush = 0;
    imemREN = 0;
    fetch(32'h000, 4, "lru_000");
    fetch(32'h040, 4, "lru_040");
    fetch(32'h000, 0, "lru_000_hit");
    fetch(32'h080, 4, "lru_080");
    fetch(32'h000, 0, "lru_000_again");
    fetch(32'h040, 4, "lru_040_evicted");
    chk("lru_miss", miss_count, 5);
    chk("lru_hits", hit_count, 8);
    wait_cfg = 3;
    fill_q.delete();
    fetch(32'h208, 10, "wait_208");
    chk("wfill_n", fill_q.size(), 2);
    chk("wfill_a0", fill_q[0], 32'h208);
    chk("wfill_a1", fill_q[1], 32'h20C);
    fetch(32'h20C, 0, "wait_20c");
    wait_cfg = 0;
    fetch(32'h100, 4, "refill_100");
    @(posedge CLK);
    #1 imemREN = 1;
    imemaddr = 32'h310;
    @(posedge CLK);
    @(posedge CLK);
    #1 flush = 1;
    @(negedge CLK);
    chk("fl_iren_on", {31'b0, iREN}, 1);
    chk("fl_iaddr", iaddr, 32'h314);
    @(posedge CLK);
    #1 flush = 0;
    imemREN = 0;
    @(negedge CLK);
    chk("fl_iren_off", {31'b0, iREN}, 0);
    @(negedge CLK);
    chk("fl_iren_idle", {31'b0, iREN}, 0);
    fetch(32'h100, 4, "after_flush_100");
    fetch(32'h310, 4, "after_flush_310");
    chk("fl_miss", miss_count, 10);
    chk("fl_hits", hit_count, 13);
    @(posedge CLK);
    #1 imemREN = 1;
    imemaddr = 32'h208;
    @(posedge CLK);
    #3 nRST = 0;
    #1;
    chk("rm_iren", {31'b0, iREN}, 0);
    chk("rm_hits", hit_count, 0);
    chk("rm_miss", miss_count, 0);
    imemREN = 0;
    @(negedge CLK);
    #1 nRST = 1;
    fetch(32'h100, 4, "post_rst_100");
    fetch(32'h20C, 4, "post_rst_20c");
    for (int i = 0; i < 20; i++) fetch(32'h104, 0, "sat_hit");
    chk("sat_main_hits", hit_count, 22);
    chk("sat_main_miss", miss_count, 2);
    chk("sat_hits", {28'b0, s_hit_count}, 15);
    chk("sat_miss", {28'b0, s_miss_count}, 2);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
